// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: returns the instruction at the active warp's PC.
// Lookups go to a small direct-mapped cache. A miss issues a single
// program-memory read and fills the cache line when the data returns.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [3:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    localparam logic [3:0] CORE_FETCH  = 4'b0001;
    localparam logic [3:0] CORE_DECODE = 4'b0010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } fetch_state_e;

    fetch_state_e                       state_q;
    logic                               mem_read_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address_q;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q;
    logic [15:0]                        hit_count_q;
    logic [15:0]                        miss_count_q;

    logic [CACHE_LINES-1:0]             valid_q;
    logic [TAG_BITS-1:0]                tag_q  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0]   data_q [CACHE_LINES];

    logic [IDX_BITS-1:0]                lookup_idx;
    logic [TAG_BITS-1:0]                lookup_tag;
    logic [IDX_BITS-1:0]                fill_idx;
    logic [TAG_BITS-1:0]                fill_tag;
    logic                               lookup_hit;
    logic                               fill_en;
    logic [15:0]                        hit_count_d;
    logic [15:0]                        miss_count_d;

    // Cache lookup for the current PC, fill address decode and saturating counter increments.
    always_comb begin
        lookup_idx   = current_pc[IDX_BITS-1:0];
        lookup_tag   = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
        // The fill uses the latched request address, so later PC changes cannot redirect it.
        fill_idx     = mem_read_address_q[IDX_BITS-1:0];
        fill_tag     = mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
        lookup_hit   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        fill_en      = (state_q == FETCHING) && mem_read_ready;
        hit_count_d  = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
        miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
    end

    // Fetch FSM with its registered outputs and hit/miss counters.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            instruction_q      <= '0;
            hit_count_q        <= 16'd0;
            miss_count_q       <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (lookup_hit) begin
                            instruction_q <= data_q[lookup_idx];
                            hit_count_q   <= hit_count_d;
                            state_q       <= FETCHED;
                        end else begin
                            mem_read_valid_q   <= 1'b1;
                            mem_read_address_q <= current_pc;
                            miss_count_q       <= miss_count_d;
                            state_q            <= FETCHING;
                        end
                    end
                end
                FETCHING: begin
                    if (mem_read_ready) begin
                        instruction_q    <= mem_read_data;
                        mem_read_valid_q <= 1'b0;
                        state_q          <= FETCHED;
                    end
                end
                FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    mem_read_valid_q <= 1'b0;
                    state_q          <= IDLE;
                end
            endcase
        end
    end

    // Line valid bits: invalidate clears all lines and overrides a coincident fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (cache_invalidate) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Line tag and data storage, written on every fill.
    // NOTE: tags and data are not reset; a line's contents are only ever
    // read when its valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_read_data;
        end
    end

    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign fetcher_state    = state_q;
    assign instruction      = instruction_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher. A behavioural program memory
// supplies data; expected instructions are queued when a fetch is launched and
// compared when the fetcher reports FETCHED.
module tb_instruction_fetcher;

    localparam logic [3:0] ST_FETCH  = 4'b0001;
    localparam logic [3:0] ST_DECODE = 4'b0010;
    localparam logic [2:0] F_IDLE     = 3'b000;
    localparam logic [2:0] F_FETCHING = 3'b001;
    localparam logic [2:0] F_FETCHED  = 3'b010;

    logic        clk;
    logic        reset;
    logic [3:0]  core_state;
    logic [7:0]  current_pc;
    logic        cache_invalidate;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int          n_checks;
    int          n_fail;
    int          exp_hits;
    int          exp_misses;
    logic [15:0] prog_mem [256];
    logic [15:0] sb_q [$];

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .CACHE_LINES(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .core_state      (core_state),
        .current_pc      (current_pc),
        .cache_invalidate(cache_invalidate),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-looking reset pulse; counters in the model restart too.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        core_state = 4'b0000;
        mem_read_ready = 1'b0;
        cache_invalidate = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        sb_q.delete();
    endtask

    task automatic check_counters(input string tag);
        n_checks++;
        if (hit_count !== exp_hits[15:0]) begin
            n_fail++;
            $display("FAIL %s hit_count: got %h expected %h", tag, hit_count, exp_hits[15:0]);
        end
        n_checks++;
        if (miss_count !== exp_misses[15:0]) begin
            n_fail++;
            $display("FAIL %s miss_count: got %h expected %h", tag, miss_count, exp_misses[15:0]);
        end
    endtask

    // One complete fetch: FETCH request, optional memory wait of lat edges,
    // a hold cycle, then the DECODE handshake back to IDLE.
    task automatic do_fetch(input logic [7:0] pc, input int lat, input bit exp_hit,
                            input bit inv_fill, input bit inv_lookup);
        int          valid_cycles;
        logic [15:0] exp_instr;
        @(negedge clk);
        core_state       = ST_FETCH;
        current_pc       = pc;
        cache_invalidate = inv_lookup;
        sb_q.push_back(prog_mem[pc]);
        @(negedge clk);
        cache_invalidate = 1'b0;
        current_pc       = ~pc;
        if (exp_hit) begin
            exp_hits++;
            n_checks++;
            if (fetcher_state !== F_FETCHED || mem_read_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_latency pc=%h: state=%b valid=%b expected state=%b valid=0",
                         pc, fetcher_state, mem_read_valid, F_FETCHED);
            end
        end else begin
            exp_misses++;
            valid_cycles = 0;
            n_checks++;
            if (fetcher_state !== F_FETCHING) begin
                n_fail++;
                $display("FAIL miss_state pc=%h: got %b expected %b", pc, fetcher_state, F_FETCHING);
            end
            for (int j = 1; j <= lat; j++) begin
                if (mem_read_valid === 1'b1 && mem_read_address === pc) valid_cycles++;
                if (j == lat) begin
                    mem_read_ready   = 1'b1;
                    mem_read_data    = prog_mem[pc];
                    cache_invalidate = inv_fill;
                end else begin
                    mem_read_ready = 1'b0;
                    mem_read_data  = 16'hDEAD;
                end
                @(negedge clk);
            end
            mem_read_ready   = 1'b0;
            cache_invalidate = 1'b0;
            n_checks++;
            if (valid_cycles != lat) begin
                n_fail++;
                $display("FAIL request_window pc=%h: valid+addr cycles %0d expected %0d", pc, valid_cycles, lat);
            end
            n_checks++;
            if (fetcher_state !== F_FETCHED || mem_read_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_done pc=%h: state=%b valid=%b expected state=%b valid=0",
                         pc, fetcher_state, mem_read_valid, F_FETCHED);
            end
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard pc=%h: no expected entry queued", pc);
            exp_instr = 16'hxxxx;
        end else begin
            exp_instr = sb_q.pop_front();
            if (instruction !== exp_instr) begin
                n_fail++;
                $display("FAIL instruction pc=%h: got %h expected %h", pc, instruction, exp_instr);
            end
        end
        // Scheduler not yet in DECODE: result must be held.
        core_state = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (fetcher_state !== F_FETCHED || instruction !== exp_instr) begin
            n_fail++;
            $display("FAIL hold pc=%h: state=%b instr=%h expected state=%b instr=%h",
                     pc, fetcher_state, instruction, F_FETCHED, exp_instr);
        end
        core_state = ST_DECODE;
        @(negedge clk);
        core_state = 4'b0000;
        n_checks++;
        if (fetcher_state !== F_IDLE) begin
            n_fail++;
            $display("FAIL decode_return pc=%h: state=%b expected %b", pc, fetcher_state, F_IDLE);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (fetcher_state !== F_IDLE || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: state=%b valid=%b addr=%h expected 000/0/00",
                     fetcher_state, mem_read_valid, mem_read_address);
        end
        n_checks++;
        if (instruction !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_instr: got %h expected 0000", instruction);
        end
        check_counters("reset");
    endtask

    task automatic test_cold_miss_and_hit();
        do_fetch(8'h05, 3, 1'b0, 1'b0, 1'b0);
        check_counters("cold_miss");
        do_fetch(8'h05, 0, 1'b1, 1'b0, 1'b0);
        check_counters("hit");
    endtask

    task automatic test_conflict();
        apply_reset();
        do_fetch(8'h01, 1, 1'b0, 1'b0, 1'b0);
        do_fetch(8'h05, 1, 1'b0, 1'b0, 1'b0);
        do_fetch(8'h01, 1, 1'b0, 1'b0, 1'b0);
        check_counters("conflict");
        do_fetch(8'h01, 0, 1'b1, 1'b0, 1'b0);
        do_fetch(8'h02, 2, 1'b0, 1'b0, 1'b0);
        do_fetch(8'h02, 0, 1'b1, 1'b0, 1'b0);
        check_counters("conflict_other_line");
    endtask

    task automatic test_invalidate();
        // Invalidate on the fill edge: data returned, line left invalid.
        do_fetch(8'h10, 2, 1'b0, 1'b1, 1'b0);
        do_fetch(8'h10, 1, 1'b0, 1'b0, 1'b0);
        // Invalidate on a lookup edge: lookup still sees old contents.
        do_fetch(8'h10, 0, 1'b1, 1'b0, 1'b1);
        do_fetch(8'h10, 1, 1'b0, 1'b0, 1'b0);
        check_counters("invalidate");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        core_state = ST_FETCH;
        current_pc = 8'h20;
        @(negedge clk);
        core_state = 4'b0000;
        n_checks++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h20) begin
            n_fail++;
            $display("FAIL async_pre: valid=%b addr=%h expected 1/20", mem_read_valid, mem_read_address);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (fetcher_state !== F_IDLE || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: state=%b valid=%b addr=%h expected 000/0/00",
                     fetcher_state, mem_read_valid, mem_read_address);
        end
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        reset = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        repeat (3) @(negedge clk);
        mem_read_ready = 1'b0;
        n_checks++;
        if (fetcher_state !== F_IDLE || mem_read_valid !== 1'b0 || instruction !== 16'h0000) begin
            n_fail++;
            $display("FAIL late_response: state=%b valid=%b instr=%h expected 000/0/0000",
                     fetcher_state, mem_read_valid, instruction);
        end
        check_counters("async_reset");
        // Late response must not have filled the cache.
        do_fetch(8'h20, 1, 1'b0, 1'b0, 1'b0);
        check_counters("async_refetch");
    endtask

    task automatic test_saturation();
        apply_reset();
        do_fetch(8'h30, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            core_state = ST_FETCH;
            current_pc = 8'h30;
            @(negedge clk);
            core_state = ST_DECODE;
            if (i == 65533) begin
                n_checks++;
                if (hit_count !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL near_saturation: got %h expected FFFE", hit_count);
                end
            end
            if (i == 65534 || i == 65539) begin
                n_checks++;
                if (hit_count !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL saturation hit %0d: got %h expected FFFF", i + 1, hit_count);
                end
            end
        end
        @(negedge clk);
        core_state = 4'b0000;
        n_checks++;
        if (miss_count !== 16'h0001 || instruction !== prog_mem[8'h30]) begin
            n_fail++;
            $display("FAIL saturation_side: miss=%h instr=%h expected 0001/%h",
                     miss_count, instruction, prog_mem[8'h30]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_hits = 0;
        exp_misses = 0;
        reset = 1'b1;
        core_state = 4'b0000;
        current_pc = 8'h00;
        cache_invalidate = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            prog_mem[i] = {i[7:0] ^ 8'h3C, ~i[7:0]};
        end
        prog_mem[8'h05] = 16'hA1B2;
        prog_mem[8'h10] = 16'h1234;

        test_reset();
        test_cold_miss_and_hit();
        test_conflict();
        test_invalidate();
        test_async_reset();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
